// File: rtl/ctrl_mch.sv
// ctrl_mch: chained DMA descriptor controller. Fetches up to NJOB descriptors per batch over a
// 64-bit Wishbone master, dispatches them to engines, writes status back and raises interrupts.
module ctrl_mch #(
    parameter int NJOB       = 2,
    parameter int DESC_BEATS = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cab_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    output logic [31:0]          wbm_dat64_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic [31:0]          wbm_dat64_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_rty_i,
    input  logic                 wbm_err_i,
    output logic [NJOB-1:0]      ss_we,
    output logic [1:0]           ss_adr,
    output logic [31:0]          ss_dat,
    output logic [NJOB*24-1:0]   ss_dc,
    output logic [NJOB-1:0]      ss_done,
    input  logic [NJOB-1:0]      c_done,
    input  logic                 enable,
    input  logic                 ndar_dirty,
    input  logic [28:0]          ndar,
    output logic                 ndar_dirty_clear,
    input  logic                 resume,
    output logic                 resume_clear,
    input  logic                 abort,
    input  logic                 wb_int_clear,
    output logic                 wb_int_o,
    output logic [1:0]           err_code,
    output logic [31:0]          dar,
    output logic                 busy,
    output logic [3:0]           ctrl_state
);
    localparam int SW = 3;
    localparam logic [1:0] LAST_BEAT = 2'(DESC_BEATS - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_NEXT = 4'd2, S_WAIT = 4'd3,
        S_CTL  = 4'd4, S_TR    = 4'd5, S_ERR  = 4'd6
    } state_t;

    state_t      state_q, state_d;
    logic [28:0] adr_q, adr_d;
    logic [1:0]  beat_q, beat_d;
    logic [SW-1:0] slot_q, slot_d, exec_q, exec_d, last_q, last_d;
    logic        resume_mode_q, resume_mode_d;
    logic        rty_hold_q, rty_hold_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [1:0]  pend_q, pend_d;
    logic [31:0] dar_q, dar_d;
    logic        ndc_q, ndc_d;
    logic        wb_int_q, wb_int_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        int_set, code_we;
    logic [1:0]  code_val;

    logic [23:0] dc_q   [NJOB];
    logic [28:0] ctl_q  [NJOB];
    logic [28:0] nxt_q  [NJOB];
    logic [28:0] cdar_q [NJOB];

    logic [23:0] slot_dc, exec_dc;
    logic [28:0] slot_nxt, exec_nxt, exec_ctl, exec_cdar;
    logic        exec_cdone;
    logic        ack_ok, rty_ev, err_ev, fetch_wr;

    assign wbm_cyc_o   = (state_q == S_FETCH) || (state_q == S_CTL);
    assign wbm_stb_o   = wbm_cyc_o && !rty_hold_q;
    assign wbm_we_o    = (state_q == S_CTL);
    assign wbm_cab_o   = wbm_cyc_o;
    assign wbm_sel_o   = {4{wbm_cyc_o}};
    assign wbm_adr_o   = {adr_q, 3'b000};
    assign wbm_dat_o   = (wbm_we_o && beat_q == 2'd0) ? {8'h80, exec_dc} : 32'h0;
    assign wbm_dat64_o = (wbm_we_o && beat_q == 2'd0) ? {29'h0, exec_q} : 32'h0;

    // An ack that coincides with err or rty is never a completed beat.
    assign ack_ok   = wbm_stb_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign rty_ev   = wbm_stb_o && wbm_rty_i && !wbm_err_i;
    assign err_ev   = wbm_stb_o && wbm_err_i;
    assign fetch_wr = (state_q == S_FETCH) && ack_ok;

    assign ss_adr           = beat_q;
    assign ss_dat           = wbm_dat_i;
    assign ndar_dirty_clear = ndc_q;
    assign resume_clear     = (state_q == S_NEXT) && resume_mode_q;
    assign wb_int_o         = wb_int_q;
    assign err_code         = err_code_q;
    assign dar              = dar_q;
    assign busy             = (state_q != S_IDLE);
    assign ctrl_state       = state_q;

    for (genvar gi = 0; gi < NJOB; gi++) begin : g_slot
        assign ss_we[gi]           = fetch_wr && (slot_q == SW'(gi)) && !resume_mode_q;
        assign ss_done[gi]         = (state_q == S_TR) && (exec_q == SW'(gi));
        assign ss_dc[24*gi +: 24]  = dc_q[gi];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NJOB; k++) begin
                dc_q[k]   <= '0;
                ctl_q[k]  <= '0;
                nxt_q[k]  <= '0;
                cdar_q[k] <= '0;
            end
        end else if (fetch_wr) begin
            for (int k = 0; k < NJOB; k++) begin
                if (slot_q == SW'(k)) begin
                    if (beat_q == 2'd0) begin
                        ctl_q[k]  <= wbm_dat_i[31:3];
                        nxt_q[k]  <= wbm_dat64_i[31:3];
                        cdar_q[k] <= adr_q;
                    end
                    if (beat_q == 2'd1) dc_q[k] <= wbm_dat64_i[23:0];
                end
            end
        end
    end

    always_comb begin
        slot_dc    = '0;
        slot_nxt   = '0;
        exec_dc    = '0;
        exec_nxt   = '0;
        exec_ctl   = '0;
        exec_cdar  = '0;
        exec_cdone = 1'b0;
        for (int k = 0; k < NJOB; k++) begin
            if (slot_q == SW'(k)) begin
                slot_dc  = dc_q[k];
                slot_nxt = nxt_q[k];
            end
            if (exec_q == SW'(k)) begin
                exec_dc    = dc_q[k];
                exec_nxt   = nxt_q[k];
                exec_ctl   = ctl_q[k];
                exec_cdar  = cdar_q[k];
                exec_cdone = c_done[k];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        beat_d        = beat_q;
        slot_d        = slot_q;
        exec_d        = exec_q;
        last_d        = last_q;
        resume_mode_d = resume_mode_q;
        rty_hold_d    = 1'b0;
        rcnt_d        = rcnt_q;
        pend_d        = pend_q;
        dar_d         = dar_q;
        ndc_d         = 1'b0;
        int_set       = 1'b0;
        code_we       = 1'b0;
        code_val      = 2'b00;
        case (state_q)
            S_IDLE: begin
                rcnt_d = '0;
                beat_d = '0;
                if (enable && ndar_dirty) begin
                    state_d       = S_FETCH;
                    adr_d         = ndar;
                    slot_d        = '0;
                    resume_mode_d = 1'b0;
                    ndc_d         = 1'b1;
                end else if (enable && resume) begin
                    state_d       = S_FETCH;
                    adr_d         = dar_q[31:3];
                    slot_d        = '0;
                    resume_mode_d = 1'b1;
                end
            end
            S_FETCH, S_CTL: begin
                if (err_ev) begin
                    state_d = S_ERR;
                    pend_d  = 2'b01;
                end else if (rty_ev) begin
                    rcnt_d = rcnt_q + 4'd1;
                    if (rcnt_d >= 4'(MAX_RETRY)) begin
                        state_d = S_ERR;
                        pend_d  = 2'b10;
                    end else begin
                        rty_hold_d = 1'b1;
                    end
                end else if (ack_ok) begin
                    rcnt_d = '0;
                    adr_d  = adr_q + 29'd1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = (state_q == S_FETCH) ? S_NEXT : S_TR;
                    end
                end
            end
            S_NEXT: begin
                // A resumed descriptor was already executed; only its chain link matters.
                if (resume_mode_q) begin
                    resume_mode_d = 1'b0;
                    if (slot_dc[14]) begin
                        state_d = S_FETCH;
                        adr_d   = slot_nxt;
                        slot_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (slot_dc[14] && (slot_q < SW'(NJOB - 1))) begin
                    state_d = S_FETCH;
                    adr_d   = slot_nxt;
                    slot_d  = slot_q + 1'b1;
                end else begin
                    state_d = S_WAIT;
                    exec_d  = '0;
                    last_d  = slot_q;
                end
            end
            S_WAIT: begin
                if (exec_cdone) begin
                    beat_d = '0;
                    if (exec_dc[7]) begin
                        state_d = S_CTL;
                        adr_d   = exec_ctl;
                    end else begin
                        state_d = S_TR;
                    end
                end
            end
            S_TR: begin
                dar_d   = {exec_cdar, 3'b000};
                int_set = exec_dc[15];
                if (exec_q < last_q) begin
                    state_d = S_WAIT;
                    exec_d  = exec_q + 1'b1;
                end else if (exec_dc[14]) begin
                    state_d = S_FETCH;
                    adr_d   = exec_nxt;
                    slot_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                int_set  = 1'b1;
                code_we  = 1'b1;
                code_val = pend_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            rty_hold_d = 1'b0;
            dar_d      = dar_q;
            int_set    = 1'b1;
            code_we    = 1'b1;
            code_val   = 2'b11;
        end

        // A set arriving with a clear wins.
        wb_int_d   = wb_int_clear ? 1'b0 : wb_int_q;
        err_code_d = wb_int_clear ? 2'b00 : err_code_q;
        if (int_set) wb_int_d = 1'b1;
        if (code_we) err_code_d = code_val;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= S_IDLE;
            adr_q         <= '0;
            beat_q        <= '0;
            slot_q        <= '0;
            exec_q        <= '0;
            last_q        <= '0;
            resume_mode_q <= 1'b0;
            rty_hold_q    <= 1'b0;
            rcnt_q        <= '0;
            pend_q        <= '0;
            dar_q         <= '0;
            ndc_q         <= 1'b0;
            wb_int_q      <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            beat_q        <= beat_d;
            slot_q        <= slot_d;
            exec_q        <= exec_d;
            last_q        <= last_d;
            resume_mode_q <= resume_mode_d;
            rty_hold_q    <= rty_hold_d;
            rcnt_q        <= rcnt_d;
            pend_q        <= pend_d;
            dar_q         <= dar_d;
            ndc_q         <= ndc_d;
            wb_int_q      <= wb_int_d;
            err_code_q    <= err_code_d;
        end
    end
endmodule

// File: tb/tb_ctrl_mch.sv
// Bench for ctrl_mch: Wishbone slave model with scripted rty/err, expected bus beats and
// retirements queued by the stimulus and consumed by an independent monitor.
module tb_ctrl_mch;
    localparam int NJOB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat64_o;
    logic [31:0] wbm_dat_i = '0, wbm_dat64_i = '0;
    logic        wbm_ack_i = 1'b0, wbm_rty_i = 1'b0, wbm_err_i = 1'b0;
    logic [NJOB-1:0]    ss_we, ss_done;
    logic [1:0]         ss_adr;
    logic [31:0]        ss_dat;
    logic [NJOB*24-1:0] ss_dc;
    logic [NJOB-1:0]    c_done = '0;
    logic        enable = 1'b0, ndar_dirty = 1'b0, resume = 1'b0, abort = 1'b0, wb_int_clear = 1'b0;
    logic [28:0] ndar = '0;
    logic        ndar_dirty_clear, resume_clear, wb_int_o, busy;
    logic [1:0]  err_code;
    logic [31:0] dar;
    logic [3:0]  ctrl_state;

    ctrl_mch #(.NJOB(NJOB), .DESC_BEATS(4), .MAX_RETRY(3)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_cab_o(wbm_cab_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat64_o(wbm_dat64_o),
        .wbm_dat_i(wbm_dat_i), .wbm_dat64_i(wbm_dat64_i),
        .wbm_ack_i(wbm_ack_i), .wbm_rty_i(wbm_rty_i), .wbm_err_i(wbm_err_i),
        .ss_we(ss_we), .ss_adr(ss_adr), .ss_dat(ss_dat), .ss_dc(ss_dc), .ss_done(ss_done),
        .c_done(c_done), .enable(enable), .ndar_dirty(ndar_dirty), .ndar(ndar),
        .ndar_dirty_clear(ndar_dirty_clear), .resume(resume), .resume_clear(resume_clear),
        .abort(abort), .wb_int_clear(wb_int_clear), .wb_int_o(wb_int_o), .err_code(err_code),
        .dar(dar), .busy(busy), .ctrl_state(ctrl_state)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] dat64;
        logic [1:0]  beat;
        logic [1:0]  we_mask;
    } bus_t;
    typedef struct {
        logic [31:0] adr;
        int          kind;   // 1 = rty, 2 = err
    } resp_t;

    bus_t        bus_q[$];
    logic [1:0]  done_q[$];
    resp_t       resp_q[$];
    logic [63:0] mem [bit [31:0]];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Slave: answers each strobe at the falling edge; scripted faults take precedence over ack.
    always @(negedge clk) begin : slave
        logic [63:0] rd;
        wbm_ack_i = 1'b0;
        wbm_rty_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (resp_q.size() > 0 && resp_q[0].adr == wbm_adr_o) begin
                if (resp_q[0].kind == 1) wbm_rty_i = 1'b1;
                else wbm_err_i = 1'b1;
                resp_q.delete(0);
            end else begin
                wbm_ack_i = 1'b1;
            end
            if (!wbm_we_o) begin
                rd = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 64'h0;
                wbm_dat_i   = rd[31:0];
                wbm_dat64_i = rd[63:32];
            end
        end
    end

    always begin : monitor
        bus_t       e;
        logic [1:0] d;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (wbm_stb_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: beat at 0x%08h we=%0d, none required", wbm_adr_o, wbm_we_o);
                end else begin
                    e = bus_q.pop_front();
                    $display("bus  adr=0x%08h we=%0d dat=0x%08h_%08h ss_we=%b beat=%0d",
                             wbm_adr_o, wbm_we_o, wbm_dat64_o, wbm_dat_o, ss_we, ss_adr);
                    chk("bus_adr", 64'(wbm_adr_o), 64'(e.adr));
                    chk("bus_we", 64'(wbm_we_o), 64'(e.we));
                    chk("ss_we", 64'(ss_we), 64'(e.we_mask));
                    chk("ss_adr", 64'(ss_adr), 64'(e.beat));
                    chk("sel_cab", 64'({wbm_sel_o, wbm_cab_o}), 64'(5'b11111));
                    if (e.we) begin
                        chk("wb_dat", 64'(wbm_dat_o), 64'(e.dat));
                        chk("wb_dat64", 64'(wbm_dat64_o), 64'(e.dat64));
                    end
                end
            end
            if (ss_done != '0) begin
                $display("done ss_done=%b dar_before=0x%08h", ss_done, dar);
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: ss_done=%b, none required", ss_done);
                end else begin
                    d = done_q.pop_front();
                    chk("ss_done", 64'(ss_done), 64'(d));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic put_desc(input bit [31:0] a, input bit [31:0] ctl, input bit [31:0] nxt, input bit [23:0] dc);
        mem[a]      = {nxt, ctl};
        mem[a + 8]  = {8'h00, dc, ~a};
        mem[a + 16] = {a, ~a};
        mem[a + 24] = {~a, a};
    endtask

    task automatic exp_fetch(input bit [31:0] a, input logic [1:0] mask, input int n);
        for (int i = 0; i < n; i++)
            bus_q.push_back('{adr: a + 32'(8 * i), we: 1'b0, dat: 32'h0, dat64: 32'h0, beat: 2'(i), we_mask: mask});
    endtask

    task automatic exp_wb(input bit [31:0] ctl, input bit [23:0] dc, input bit [2:0] ex);
        bus_q.push_back('{adr: ctl, we: 1'b1, dat: {8'h80, dc}, dat64: {29'h0, ex}, beat: 2'd0, we_mask: 2'b00});
        for (int i = 1; i < 4; i++)
            bus_q.push_back('{adr: ctl + 32'(8 * i), we: 1'b1, dat: 32'h0, dat64: 32'h0, beat: 2'(i), we_mask: 2'b00});
    endtask

    task automatic start_ndar(input bit [31:0] a);
        logic seen;
        seen = 1'b0;
        ndar = a[31:3];
        ndar_dirty = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ndar_dirty_clear) seen = 1'b1;
        end
        ndar_dirty = 1'b0;
        chk("ndar_dirty_clear_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        step();
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk({name, "_idle_reached"}, 64'(busy), 64'd0);
        chk({name, "_bus_drained"}, 64'(bus_q.size()), 64'd0);
        chk({name, "_done_drained"}, 64'(done_q.size()), 64'd0);
    endtask

    task automatic clear_int();
        wb_int_clear = 1'b1;
        step();
        wb_int_clear = 1'b0;
        chk("int_cleared", 64'(wb_int_o), 64'd0);
        chk("err_cleared", 64'(err_code), 64'd0);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dar", 64'(dar), 64'd0);
        chk("rst_int_err", 64'({wb_int_o, err_code}), 64'd0);
        chk("rst_pulses", 64'({ss_done, ss_we, ndar_dirty_clear, resume_clear}), 64'd0);
        chk("rst_state", 64'(ctrl_state), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        c_done = 2'b11;
        step();

        // Two-slot chained batch
        put_desc(32'h100, 32'h1000, 32'h200, 24'h004000);
        put_desc(32'h200, 32'h1100, 32'h000, 24'h008000);
        exp_fetch(32'h100, 2'b01, 4);
        exp_fetch(32'h200, 2'b10, 4);
        done_q.push_back(2'b01);
        done_q.push_back(2'b10);
        start_ndar(32'h100);
        wait_idle("t1");
        chk("t1_dar", 64'(dar), 64'h200);
        chk("t1_int", 64'(wb_int_o), 64'd1);
        chk("t1_err", 64'(err_code), 64'd0);
        clear_int();

        // Resume from dar: re-read without slot strobes, then follow its chain
        put_desc(32'h200, 32'h1100, 32'h300, 24'h004000);
        put_desc(32'h300, 32'h0000, 32'h000, 24'h008000);
        exp_fetch(32'h200, 2'b00, 4);
        exp_fetch(32'h300, 2'b01, 4);
        done_q.push_back(2'b01);
        resume = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (resume_clear) seen = 1'b1;
        end
        resume = 1'b0;
        chk("t5_resume_clear_seen", 64'(seen), 64'd1);
        wait_idle("t5");
        chk("t5_dar", 64'(dar), 64'h300);
        chk("t5_int", 64'(wb_int_o), 64'd1);
        clear_int();

        // Status writeback
        put_desc(32'h500, 32'h400, 32'h000, 24'h000080);
        exp_fetch(32'h500, 2'b01, 4);
        exp_wb(32'h400, 24'h000080, 3'd0);
        done_q.push_back(2'b01);
        start_ndar(32'h500);
        wait_idle("t2");
        chk("t2_dar", 64'(dar), 64'h500);
        chk("t2_int", 64'(wb_int_o), 64'd0);

        // Two retries then ack completes; three consecutive retries abort with code 10
        put_desc(32'h600, 32'h0, 32'h0, 24'h000000);
        resp_q.push_back('{adr: 32'h610, kind: 1});
        resp_q.push_back('{adr: 32'h610, kind: 1});
        exp_fetch(32'h600, 2'b01, 4);
        done_q.push_back(2'b01);
        start_ndar(32'h600);
        wait_idle("t3a");
        chk("t3a_rty_consumed", 64'(resp_q.size()), 64'd0);
        chk("t3a_dar", 64'(dar), 64'h600);
        chk("t3a_err", 64'(err_code), 64'd0);
        put_desc(32'h700, 32'h0, 32'h0, 24'h000000);
        for (int i = 0; i < 3; i++) resp_q.push_back('{adr: 32'h710, kind: 1});
        exp_fetch(32'h700, 2'b01, 2);
        start_ndar(32'h700);
        wait_idle("t3b");
        chk("t3b_err", 64'(err_code), 64'd2);
        chk("t3b_int", 64'(wb_int_o), 64'd1);
        chk("t3b_dar", 64'(dar), 64'h600);
        clear_int();

        // Bus error on beat1 of slot1 fetch
        put_desc(32'h800, 32'h0, 32'h900, 24'h004000);
        put_desc(32'h900, 32'h0, 32'h000, 24'h000000);
        resp_q.push_back('{adr: 32'h908, kind: 2});
        exp_fetch(32'h800, 2'b01, 4);
        exp_fetch(32'h900, 2'b10, 1);
        start_ndar(32'h800);
        n = 0;
        while (!wbm_err_i && n < 50) begin
            step();
            n++;
        end
        chk("t4_err_seen", 64'(wbm_err_i), 64'd1);
        step();
        chk("t4_cyc_low", 64'(wbm_cyc_o), 64'd0);
        step();
        chk("t4_err", 64'(err_code), 64'd1);
        chk("t4_int", 64'(wb_int_o), 64'd1);
        wait_idle("t4");
        chk("t4_dar", 64'(dar), 64'h600);
        clear_int();

        // Abort while waiting for the engine
        c_done = 2'b00;
        put_desc(32'hA00, 32'h0, 32'h0, 24'h000000);
        exp_fetch(32'hA00, 2'b01, 4);
        start_ndar(32'hA00);
        n = 0;
        while (ctrl_state != 4'd3 && n < 50) begin
            step();
            n++;
        end
        chk("t6_in_wait", 64'(ctrl_state), 64'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_err", 64'(err_code), 64'd3);
        chk("t6_int", 64'(wb_int_o), 64'd1);
        clear_int();
        repeat (3) step();
        chk("t6_bus_drained", 64'(bus_q.size()), 64'd0);
        chk("t6_done_drained", 64'(done_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
